// File: rtl/obi_scratchpad_responder_if.sv
// ---------------------------------------------------------------------------
// obi_scratchpad_responder_if
// OBI request/response bundle between a requester (bridge) and the
// scratchpad responder.
//   req_i    request valid            (requester -> responder)
//   gnt_o    grant                    (responder -> requester)
//   addr_i   32-bit byte address      (requester -> responder)
//   we_i     1 = write, 0 = read      (requester -> responder)
//   be_i     byte enables (writes)    (requester -> responder)
//   wdata_i  write data               (requester -> responder)
//   rvalid_o response valid pulse     (responder -> requester)
//   rdata_o  read data, 0 for writes  (responder -> requester)
//   err_o    out-of-range flag        (only when OBI_SPM_ERR_EN is defined)
// Signal names keep the responder-side suffixes so they read the same as the
// responder's port list.
// ---------------------------------------------------------------------------
interface obi_scratchpad_responder_if;
    logic        req_i;
    logic        gnt_o;
    logic [31:0] addr_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] wdata_i;
    logic        rvalid_o;
    logic [31:0] rdata_o;
`ifdef OBI_SPM_ERR_EN
    logic        err_o;
`endif

    modport slave (
        input  req_i, addr_i, we_i, be_i, wdata_i,
`ifdef OBI_SPM_ERR_EN
        output err_o,
`endif
        output gnt_o, rvalid_o, rdata_o
    );

    modport master (
        output req_i, addr_i, we_i, be_i, wdata_i,
`ifdef OBI_SPM_ERR_EN
        input  err_o,
`endif
        input  gnt_o, rvalid_o, rdata_o
    );
endinterface

// File: rtl/obi_scratchpad_responder.sv
// ---------------------------------------------------------------------------
// obi_scratchpad_responder
// OBI responder in front of a single-port 32-bit scratchpad bank. Serves one
// transaction at a time: grant, LATENCY wait cycles, memory access, then a
// single-cycle rvalid pulse. A request arriving in the response cycle is
// granted immediately (back-to-back).
//
// Parameters
//   NUM_WORDS  bank depth in 32-bit words (power of two, >= 2)
//   LATENCY    wait cycles between grant and the memory access (0..15)
//
// Ports
//   clk_i   clock
//   rst_ni  asynchronous active-low reset
//   bus     obi_scratchpad_responder_if.slave (req/gnt/addr/we/be/wdata,
//           rvalid/rdata and, when enabled, err)
//
// Optional feature
//   OBI_SPM_ERR_EN : when defined, addresses with any bit set above the bank
//   range are answered with err_o = 1, rdata_o = 0, and writes are dropped.
//   When undefined, upper address bits are ignored (addresses alias).
// ---------------------------------------------------------------------------
module obi_scratchpad_responder #(
    parameter int NUM_WORDS = 1024,
    parameter int LATENCY   = 0
) (
    input logic                       clk_i,
    input logic                       rst_ni,
    obi_scratchpad_responder_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RSP} state_e;

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;

    // Request fields captured at grant; only consumed when LATENCY > 0.
    logic [IDX_W-1:0] cap_idx_q;
    logic             cap_we_q;
    logic             cap_oor_q;
    logic [3:0]       cap_be_q;
    logic [31:0]      cap_wdata_q;

    logic [31:0]      mem [NUM_WORDS];
    logic [31:0]      rdata_q;
`ifdef OBI_SPM_ERR_EN
    logic             err_q;
`endif

    logic             grant;
    logic             req_oor;
    logic             acc_en;
    logic             acc_we;
    logic             acc_oor;
    logic [IDX_W-1:0] acc_idx;
    logic [3:0]       acc_be;
    logic [31:0]      acc_wdata;

`ifdef OBI_SPM_ERR_EN
    assign req_oor = |bus.addr_i[31:2+IDX_W];
`else
    assign req_oor = 1'b0;
`endif

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_word;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[8*b +: 8] = new_word[8*b +: 8];
        end
        return res;
    endfunction

    // Next state, grant, and selection of the fields used by the access:
    // live bus fields for an immediate (zero-latency) access, captured
    // fields once the access has been deferred into WAIT.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        grant     = 1'b0;
        acc_en    = 1'b0;
        acc_idx   = bus.addr_i[2 +: IDX_W];
        acc_we    = bus.we_i;
        acc_be    = bus.be_i;
        acc_wdata = bus.wdata_i;
        acc_oor   = req_oor;
        unique case (state_q)
            IDLE, RSP: begin
                grant = bus.req_i;
                if (grant) begin
                    if (LATENCY == 0) begin
                        acc_en  = 1'b1;
                        state_d = RSP;
                    end else begin
                        cnt_d   = 4'(LATENCY);
                        state_d = WAIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                cnt_d     = cnt_q - 4'd1;
                acc_idx   = cap_idx_q;
                acc_we    = cap_we_q;
                acc_be    = cap_be_q;
                acc_wdata = cap_wdata_q;
                acc_oor   = cap_oor_q;
                if (cnt_q == 4'd1) begin
                    acc_en  = 1'b1;
                    state_d = RSP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state and response registers; rdata/err are loaded in the
    // access cycle so they become visible together with rvalid.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
`ifdef OBI_SPM_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (acc_en) begin
                rdata_q <= (acc_we || acc_oor) ? 32'd0 : mem[acc_idx];
`ifdef OBI_SPM_ERR_EN
                err_q   <= acc_oor;
`endif
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (grant) begin
            cap_idx_q   <= bus.addr_i[2 +: IDX_W];
            cap_we_q    <= bus.we_i;
            cap_oor_q   <= req_oor;
            cap_be_q    <= bus.be_i;
            cap_wdata_q <= bus.wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (acc_en && acc_we && !acc_oor) begin
            mem[acc_idx] <= merge_bytes(mem[acc_idx], acc_wdata, acc_be);
        end
    end

    assign bus.gnt_o    = grant;
    assign bus.rvalid_o = (state_q == RSP);
    assign bus.rdata_o  = rdata_q;
`ifdef OBI_SPM_ERR_EN
    assign bus.err_o    = err_q & (state_q == RSP);
`endif
endmodule

// File: tb/tb_obi_scratchpad_responder.sv
// ---------------------------------------------------------------------------
// tb_obi_scratchpad_responder
// Three responders (LATENCY 0, 3, 5) share clock, reset and request fields;
// each has its own req line. A word-array model of every bank supplies the
// expected read data and error flags.
// ---------------------------------------------------------------------------
module tb_obi_scratchpad_responder;
    localparam int NW = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req_d;
    logic        we_d;
    logic [31:0] addr_d;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;

    logic [2:0]  gnt_s;
    logic [2:0]  rvalid_s;
    logic [31:0] rdata_s [3];
`ifdef OBI_SPM_ERR_EN
    logic [2:0]  err_s;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] mdl [3][NW];

    always #5 clk = ~clk;

    obi_scratchpad_responder_if bus0();
    obi_scratchpad_responder_if bus1();
    obi_scratchpad_responder_if bus2();

    assign bus0.req_i = req_d[0];
    assign bus1.req_i = req_d[1];
    assign bus2.req_i = req_d[2];
    assign bus0.we_i = we_d;     assign bus1.we_i = we_d;     assign bus2.we_i = we_d;
    assign bus0.addr_i = addr_d; assign bus1.addr_i = addr_d; assign bus2.addr_i = addr_d;
    assign bus0.be_i = be_d;     assign bus1.be_i = be_d;     assign bus2.be_i = be_d;
    assign bus0.wdata_i = wdata_d; assign bus1.wdata_i = wdata_d; assign bus2.wdata_i = wdata_d;

    assign gnt_s    = {bus2.gnt_o, bus1.gnt_o, bus0.gnt_o};
    assign rvalid_s = {bus2.rvalid_o, bus1.rvalid_o, bus0.rvalid_o};
    assign rdata_s[0] = bus0.rdata_o;
    assign rdata_s[1] = bus1.rdata_o;
    assign rdata_s[2] = bus2.rdata_o;
`ifdef OBI_SPM_ERR_EN
    assign err_s = {bus2.err_o, bus1.err_o, bus0.err_o};
`endif

    obi_scratchpad_responder #(.NUM_WORDS(NW), .LATENCY(0)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus0.slave));
    obi_scratchpad_responder #(.NUM_WORDS(NW), .LATENCY(3)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus1.slave));
    obi_scratchpad_responder #(.NUM_WORDS(NW), .LATENCY(5)) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus2.slave));

    function automatic int lat_of(input int s);
        return (s == 0) ? 0 : (s == 1) ? 3 : 5;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Reference: word index wraps modulo bank size; with the error feature
    // any address at or beyond the bank size is rejected.
    task automatic model_access(input int s, input bit w, input logic [31:0] a,
                                input logic [3:0] b, input logic [31:0] d,
                                output logic [31:0] ex, output logic ee);
        int idx;
        bit oor;
        idx = int'((a >> 2) % 32'(NW));
        oor = 1'b0;
`ifdef OBI_SPM_ERR_EN
        oor = (a >= 32'(NW * 4));
`endif
        ee = oor;
        ex = 32'd0;
        if (!oor) begin
            if (!w) ex = mdl[s][idx];
            else begin
                for (int i = 0; i < 4; i++)
                    if (b[i]) mdl[s][idx][8*i +: 8] = d[8*i +: 8];
            end
        end
    endtask

    task automatic txn(input int s, input bit w, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] d,
                       input bit hold, output logic [31:0] got);
        int L;
        logic [31:0] ex;
        logic ee;
        L = lat_of(s);
        model_access(s, w, a, b, d, ex, ee);
        @(negedge clk);
        req_d[s] = 1'b1; we_d = w; addr_d = a; be_d = b; wdata_d = d;
        #1 chk1("gnt_on_req", gnt_s[s], 1'b1);
        @(posedge clk);
        #1;
        if (!hold) req_d[s] = 1'b0;
        we_d = 1'($urandom); addr_d = $urandom; be_d = 4'($urandom); wdata_d = $urandom;
        for (int k = 0; k < L; k++) begin
            @(negedge clk);
            chk1("rvalid_in_wait", rvalid_s[s], 1'b0);
            if (hold) chk1("gnt_in_wait", gnt_s[s], 1'b0);
        end
        @(negedge clk);
        req_d[s] = 1'b0;
        chk1("rvalid", rvalid_s[s], 1'b1);
        chk("rdata", rdata_s[s], ex);
`ifdef OBI_SPM_ERR_EN
        chk1("err", err_s[s], ee);
`endif
        got = rdata_s[s];
        @(negedge clk);
        chk1("rvalid_pulse_end", rvalid_s[s], 1'b0);
        chk("rdata_hold", rdata_s[s], ex);
`ifdef OBI_SPM_ERR_EN
        chk1("err_idle", err_s[s], 1'b0);
`endif
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] old1;
        logic [31:0] old5;
        logic [31:0] exp1;
        logic [31:0] bad_d;
        logic [31:0] ba [4];
        logic [31:0] bex [4];
        logic ee;

        rst_n = 1'b0; req_d = 3'b000; we_d = 1'b0; addr_d = 32'd0; be_d = 4'd0; wdata_d = 32'd0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            chk1("reset_rvalid", rvalid_s[s], 1'b0);
            chk("reset_rdata", rdata_s[s], 32'd0);
            chk1("reset_gnt", gnt_s[s], 1'b0);
`ifdef OBI_SPM_ERR_EN
            chk1("reset_err", err_s[s], 1'b0);
`endif
        end
        rst_n = 1'b1;

        // Preload words 0..31 of every bank.
        for (int s = 0; s < 3; s++)
            for (int i = 0; i < 32; i++)
                txn(s, 1'b1, 32'(i * 4), 4'hF, $urandom, 1'b0, got);

        txn(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0, got);
        chk("write_rdata_zero", got, 32'd0);
        txn(0, 1'b0, 32'h10, 4'h0, 32'd0, 1'b0, got);
        chk("read_deadbeef", got, 32'hDEADBEEF);

        txn(0, 1'b1, 32'h20, 4'hF, 32'h11223344, 1'b0, got);
        txn(0, 1'b1, 32'h20, 4'b0101, 32'hAABBCCDD, 1'b0, got);
        txn(0, 1'b0, 32'h20, 4'h0, 32'd0, 1'b0, got);
        chk("partial_write", got, 32'h11BB33DD);
        txn(0, 1'b1, 32'h20, 4'b0000, 32'hFFFFFFFF, 1'b0, got);
        txn(0, 1'b0, 32'h20, 4'h0, 32'd0, 1'b0, got);
        chk("be_zero_write", got, 32'h11BB33DD);

        // LATENCY=3 with req held high through the wait states.
        txn(1, 1'b1, 32'h30, 4'hF, 32'hCAFEF00D, 1'b1, got);
        txn(1, 1'b0, 32'h30, 4'h0, 32'd0, 1'b1, got);
        chk("lat3_read", got, 32'hCAFEF00D);

        // Back-to-back reads at LATENCY=0.
        for (int i = 0; i < 4; i++) begin
            ba[i] = 32'($urandom_range(0, 31) * 4);
            model_access(0, 1'b0, ba[i], 4'h0, 32'd0, bex[i], ee);
        end
        @(negedge clk);
        req_d[0] = 1'b1; we_d = 1'b0; addr_d = ba[0];
        #1 chk1("b2b_gnt0", gnt_s[0], 1'b1);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk1("b2b_rvalid", rvalid_s[0], 1'b1);
            chk("b2b_rdata", rdata_s[0], bex[i-1]);
            if (i < 4) begin
                addr_d = ba[i];
                #1 chk1("b2b_gnt", gnt_s[0], 1'b1);
            end else begin
                req_d[0] = 1'b0;
            end
        end
        @(negedge clk);
        chk1("b2b_rvalid_end", rvalid_s[0], 1'b0);

        // Address above the bank range.
        old1 = mdl[0][1];
        bad_d = $urandom;
        txn(0, 1'b1, 32'h0000_1004, 4'hF, bad_d, 1'b0, got);
        chk("oor_write_rdata", got, 32'd0);
        txn(0, 1'b0, 32'h0000_1004, 4'h0, 32'd0, 1'b0, got);
`ifdef OBI_SPM_ERR_EN
        exp1 = 32'd0;
`else
        exp1 = bad_d;
`endif
        chk("oor_read", got, exp1);
        txn(0, 1'b0, 32'h4, 4'h0, 32'd0, 1'b0, got);
`ifdef OBI_SPM_ERR_EN
        exp1 = old1;
`else
        exp1 = bad_d;
`endif
        chk("word1_after_oor", got, exp1);

        // Randomized traffic across all three banks.
        for (int n = 0; n < 60; n++) begin
            txn($urandom_range(0, 2), 1'($urandom),
                32'($urandom_range(0, 31) * 4) | (32'($urandom_range(0, 3)) << 12 & 32'h0),
                4'($urandom), $urandom, 1'b0, got);
        end

        // Reset two cycles after a LATENCY=5 write grant drops the write.
        old5 = mdl[2][5];
        @(negedge clk);
        req_d[2] = 1'b1; we_d = 1'b1; addr_d = 32'h14; be_d = 4'hF; wdata_d = ~old5;
        #1 chk1("rst_gnt", gnt_s[2], 1'b1);
        @(posedge clk);
        #1 req_d[2] = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk1("rst_rvalid_low", rvalid_s[2], 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk1("no_rvalid_after_rst", rvalid_s[2], 1'b0);
        end
        chk("rdata_after_rst", rdata_s[2], 32'd0);
        txn(2, 1'b0, 32'h14, 4'h0, 32'd0, 1'b0, got);
        chk("word_unchanged_after_rst", got, old5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
